bcd_timer_ctrl: RTL and testbench
=================================

BCD_TIMER_CTRL -- requirements
Module: bcd_timer_ctrl

Interface
REQ-001 Parameter: TICK_DIV, default 10, clock cycles per count increment; legal range 2..1023.
REQ-002 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  level-sampled command: begin or resume counting.
REQ-005 Port: stop  input  1  level-sampled command: pause counting.
REQ-006 Port: clear  input  1  level-sampled command: return to IDLE and zero the count.
REQ-007 Port: target  input  16  four BCD digits [15:12]..[3:0]; expiry value.
REQ-008 Port: count  output  16  current four-digit BCD count.
REQ-009 Port: running  output  1  high while the state is RUN.
REQ-010 Port: expired  output  1  high while the state is DONE.
REQ-011 Port: digit_carry  output  4  per-digit "at 9 and incrementing" flags, for observation.

Function
REQ-012 FSM states: IDLE, RUN, PAUSE, DONE; the state and all outputs are registered.
REQ-013 Priority per edge: reset > clear > FSM transitions.
REQ-014 clear, in any state: state to IDLE, count to 0000, prescaler to 0.
REQ-015 IDLE, start=1 and stop=0: latch target into target_q; clear prescaler; go to RUN; count unchanged.
REQ-016 RUN, stop=1: go to PAUSE; hold count and prescaler; start in the same cycle is ignored.
REQ-017 PAUSE, start=1 and stop=0: go to RUN; prescaler resumes from its held value; target is not relatched.
REQ-018 DONE: hold count; ignore start and stop; leave only via clear or reset.
REQ-019 Prescaler in RUN: increments each cycle; tick = (prescaler == TICK_DIV-1); wraps to 0 on tick.
REQ-020 Latency: start sampled at edge E0 gives the first count update at edge E0+TICK_DIV.
REQ-021 Increment on tick:
- digit0 always increments.
- digit k increments only when all lower digits are 9.
- a digit at 9 that increments wraps to 0.
REQ-022 Wrap-around: 9999 increments to 0000 with no other side effect.
REQ-023 Expiry: on a tick whose next count equals target_q, count takes that value and the state goes to DONE on the same edge.
REQ-024 target_q = 0000: expiry occurs on the 9999-to-0000 wrap (after 10000 ticks from 0000).
REQ-025 target_q containing any nibble above 9: never matches; counting wraps indefinitely.
REQ-026 digit_carry[k] is high on ticks where digits 0..k are all 9.
REQ-027 Any input change outside RUN does not alter count.

Reset
REQ-028 reset: state IDLE, count 0000, prescaler 0, target_q 0000, running 0, expired 0, digit_carry 0000.
REQ-029 reset mid-RUN or mid-PAUSE: takes effect on the next edge; no tick is generated on that edge.

Structure
REQ-030 Shared package bcd_pkg holds: the state enumeration (IDLE, RUN, PAUSE, DONE), the BCD digit width constant 4, the digit count constant 4, and the constant BCD_MAX = 9.
REQ-031 One sub-module, bcd_digit:
- a single decade counter with enable, synchronous clear and a carry-out at 9;
- instantiated four times and chained through carries.

Verification (TICK_DIV=2 unless stated)
REQ-032 reset, then start at E0 -> running=1 at E0+1; count=0001 at E0+2; count=0010 at E0+20.
REQ-033 target=0003, start -> count steps 0001, 0002, 0003; expired=1 on the edge that count becomes 0003; count holds; further start is ignored.
REQ-034 stop after count=0005, wait 10 cycles, start -> count stays 0005 throughout the pause; the next increment arrives at the remaining prescaler offset.
REQ-035 Preload path: run from 0998 with target=1000 -> 0999 then 1000 with expired=1; digit_carry=0111 on the 0999->1000 tick.
REQ-036 target=00A0, run through 9999 -> wraps to 0000; expired stays 0.
REQ-037 clear and start together in RUN -> state IDLE, count=0000; a later start alone -> RUN.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the four-digit BCD timer.
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;
  localparam int PS_W       = 10;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
endpackage

// File: rtl/bcd_timer_ctrl_if.sv
// Command/status bundle between a controller and the BCD timer.
interface bcd_timer_ctrl_if;
  import bcd_pkg::*;

  logic                                     start;
  logic                                     stop;
  logic                                     clear;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]       target;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]       count;
  logic                                     running;
  logic                                     expired;
  logic [NUM_DIGITS-1:0]                    digit_carry;

  modport master (
    output start, stop, clear, target,
    input  count, running, expired, digit_carry
  );

  modport slave (
    input  start, stop, clear, target,
    output count, running, expired, digit_carry
  );
endinterface

// File: rtl/bcd_digit.sv
// One decade counter: enable, synchronous clear, carry-out while enabled at 9.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               en_i,
  output logic [DIGIT_W-1:0] q_o,
  output logic [DIGIT_W-1:0] d_o,
  output logic               co_o
);
  logic [DIGIT_W-1:0] q_q, q_d;

  assign co_o = en_i && (q_q == BCD_MAX);

  always_comb begin
    q_d = q_q;
    if (clr_i)     q_d = '0;
    else if (en_i) q_d = co_o ? '0 : q_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q_o = q_q;
  assign d_o = q_d;
endmodule

// File: rtl/bcd_timer_ctrl.sv
// Four-digit BCD up-timer with prescaler, pause/resume and target expiry.
module bcd_timer_ctrl
  import bcd_pkg::*;
#(
  parameter int TICK_DIV = 10
) (
  input logic              clk,
  input logic              reset,
  bcd_timer_ctrl_if.slave  bus
);
  state_e                             state_q;
  logic [PS_W-1:0]                    ps_q;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] target_q;
  logic                               running_q, expired_q;
  logic [NUM_DIGITS-1:0]              carry_q;

  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] q, d;
  logic [NUM_DIGITS-1:0]              en, co;
  logic                               run_go, tick, hit;

  // stop or clear in RUN freezes the prescaler, so neither may tick
  assign run_go = (state_q == RUN) && !bus.clear && !bus.stop;
  assign tick   = run_go && (ps_q == PS_W'(TICK_DIV - 1));
  // digits never exceed 9, so a target with an illegal nibble never hits
  assign hit    = tick && (d == target_q);

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    if (g == 0) begin : g_lsd
      assign en[g] = tick;
    end else begin : g_upper
      assign en[g] = co[g-1];
    end
    bcd_digit u_digit (
      .clk   (clk),
      .reset (reset),
      .clr_i (bus.clear),
      .en_i  (en[g]),
      .q_o   (q[g]),
      .d_o   (d[g]),
      .co_o  (co[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ps_q      <= '0;
      target_q  <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      carry_q   <= '0;
    end else begin
      carry_q <= co;
      if (bus.clear) begin
        state_q   <= IDLE;
        ps_q      <= '0;
        running_q <= 1'b0;
        expired_q <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: if (bus.start && !bus.stop) begin
            target_q  <= bus.target;
            ps_q      <= '0;
            state_q   <= RUN;
            running_q <= 1'b1;
          end
          RUN: begin
            if (bus.stop) begin
              state_q   <= PAUSE;
              running_q <= 1'b0;
            end else if (tick) begin
              ps_q <= '0;
              if (hit) begin
                state_q   <= DONE;
                running_q <= 1'b0;
                expired_q <= 1'b1;
              end
            end else begin
              ps_q <= ps_q + 1'b1;
            end
          end
          PAUSE: if (bus.start && !bus.stop) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
          DONE: ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.count       = q;
  assign bus.running     = running_q;
  assign bus.expired     = expired_q;
  assign bus.digit_carry = carry_q;
endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Directed bench for bcd_timer_ctrl at TICK_DIV=2; expectations hand-derived.
module tb_bcd_timer_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  bcd_timer_ctrl_if bus ();

  bcd_timer_ctrl #(.TICK_DIV(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [15:0] tgt);
    bus.target = tgt;
    bus.start  = 1'b1;
    cyc(1);
    bus.start  = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    cyc(1);
    bus.clear = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.stop   = 1'b0;
    bus.clear  = 1'b0;
    bus.target = 16'h0000;
    cyc(2);
    chk("rst_count",   bus.count,             16'h0000);
    chk("rst_running", {15'd0, bus.running},  16'h0000);
    chk("rst_expired", {15'd0, bus.expired},  16'h0000);
    chk("rst_carry",   {12'd0, bus.digit_carry}, 16'h0000);
    reset = 1'b0;
    cyc(1);

    // basic latency: start at E0, first count at E0+2, 0010 at E0+20
    go(16'h0050);
    cyc(1);
    chk("lat_running", {15'd0, bus.running}, 16'h0001);
    chk("lat_e1",      bus.count,            16'h0000);
    cyc(1);
    chk("lat_e2",      bus.count,            16'h0001);
    cyc(18);
    chk("lat_e20",     bus.count,            16'h0010);
    do_clear();
    chk("clr_count",   bus.count,            16'h0000);
    chk("clr_running", {15'd0, bus.running}, 16'h0000);

    // expiry at 0003, then start ignored
    go(16'h0003);
    cyc(2);
    chk("exp_1",  bus.count, 16'h0001);
    cyc(2);
    chk("exp_2",  bus.count, 16'h0002);
    chk("exp_2e", {15'd0, bus.expired}, 16'h0000);
    cyc(2);
    chk("exp_3",  bus.count, 16'h0003);
    chk("exp_3e", {15'd0, bus.expired}, 16'h0001);
    chk("exp_3r", {15'd0, bus.running}, 16'h0000);
    bus.start = 1'b1;
    cyc(4);
    bus.start = 1'b0;
    chk("exp_hold",  bus.count, 16'h0003);
    chk("exp_holde", {15'd0, bus.expired}, 16'h0001);
    do_clear();
    chk("exp_clr", {15'd0, bus.expired}, 16'h0000);

    // pause with prescaler at 1, resume ticks one cycle later
    go(16'h0050);
    cyc(10);
    chk("pz_5", bus.count, 16'h0005);
    cyc(1);
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    chk("pz_stop",    bus.count, 16'h0005);
    chk("pz_running", {15'd0, bus.running}, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      bus.target = 16'h0006;
      cyc(1);
      chk("pz_hold", bus.count, 16'h0005);
    end
    bus.target = 16'h0050;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    chk("pz_resume", bus.count, 16'h0005);
    chk("pz_run",    {15'd0, bus.running}, 16'h0001);
    cyc(1);
    chk("pz_6", bus.count, 16'h0006);
    cyc(2);
    chk("pz_7", bus.count, 16'h0007);
    do_clear();

    // carry chain into the thousands digit with expiry at 1000
    go(16'h1000);
    cyc(1996);
    chk("cy_0998", bus.count, 16'h0998);
    cyc(2);
    chk("cy_0999",  bus.count, 16'h0999);
    chk("cy_0999c", {12'd0, bus.digit_carry}, 16'h0000);
    cyc(2);
    chk("cy_1000",  bus.count, 16'h1000);
    chk("cy_1000c", {12'd0, bus.digit_carry}, 16'h0007);
    chk("cy_1000e", {15'd0, bus.expired}, 16'h0001);
    cyc(1);
    chk("cy_idlec", {12'd0, bus.digit_carry}, 16'h0000);
    chk("cy_hold",  bus.count, 16'h1000);
    do_clear();

    // illegal target: wraps 9999 -> 0000 without expiring
    go(16'h00A0);
    cyc(19998);
    chk("wr_9999", bus.count, 16'h9999);
    cyc(2);
    chk("wr_0000",  bus.count, 16'h0000);
    chk("wr_exp",   {15'd0, bus.expired}, 16'h0000);
    chk("wr_run",   {15'd0, bus.running}, 16'h0001);
    chk("wr_carry", {12'd0, bus.digit_carry}, 16'h000F);
    cyc(2);
    chk("wr_0001", bus.count, 16'h0001);
    do_clear();

    // clear beats start in RUN
    go(16'h0050);
    cyc(6);
    chk("cs_3", bus.count, 16'h0003);
    bus.clear = 1'b1;
    bus.start = 1'b1;
    cyc(1);
    bus.clear = 1'b0;
    bus.start = 1'b0;
    chk("cs_count", bus.count, 16'h0000);
    chk("cs_run",   {15'd0, bus.running}, 16'h0000);
    cyc(3);
    chk("cs_idle",  bus.count, 16'h0000);
    go(16'h0050);
    chk("cs_rerun", {15'd0, bus.running}, 16'h0001);
    cyc(2);
    chk("cs_1", bus.count, 16'h0001);

    // reset on a would-be tick edge
    do_clear();
    go(16'h0050);
    cyc(3);
    chk("rr_1", bus.count, 16'h0001);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("rr_count", bus.count, 16'h0000);
    chk("rr_run",   {15'd0, bus.running}, 16'h0000);
    cyc(4);
    chk("rr_idle",  bus.count, 16'h0000);

    // target 0000 expires on the full wrap
    go(16'h0000);
    cyc(19998);
    chk("z_9999", bus.count, 16'h9999);
    chk("z_exp0", {15'd0, bus.expired}, 16'h0000);
    cyc(2);
    chk("z_0000", bus.count, 16'h0000);
    chk("z_exp1", {15'd0, bus.expired}, 16'h0001);
    cyc(2);
    chk("z_hold", bus.count, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
